// File: rtl/bram_stream_reader.sv
// Read-side master for a 1-cycle-latency block RAM: issues a contiguous run of reads and
// re-emits the words as a valid/ready stream with a last flag, one beat per clock when unstalled.
module bram_stream_reader #(
  parameter int unsigned MEMWIDTH   = 10,
  parameter int unsigned DATAWIDTH  = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [MEMWIDTH-1:0]  start_addr,
  input  logic [MEMWIDTH:0]    length,
  output logic                 busy,
  output logic                 done,
  output logic [MEMWIDTH-1:0]  raddr,
  input  logic [DATAWIDTH-1:0] rdata,
  output logic [DATAWIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0]     DepthCnt = CntW'(FIFO_DEPTH);
  localparam logic [CntW:0]       DepthOcc = (CntW + 1)'(FIFO_DEPTH);
  localparam logic [MEMWIDTH:0]   LenOne   = (MEMWIDTH + 1)'(1);
  localparam logic [MEMWIDTH-1:0] AddrOne  = MEMWIDTH'(1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

  state_e r_state;
  state_e w_state_next;

  logic [MEMWIDTH-1:0] r_raddr;
  logic [MEMWIDTH-1:0] r_next_addr;
  logic [MEMWIDTH:0]   r_remaining;
  logic [1:0]          r_tag_v;
  logic [1:0]          r_tag_last;

  logic [DATAWIDTH:0]  r_fifo [FIFO_DEPTH];
  logic [PtrW-1:0]     r_wr_ptr;
  logic [PtrW-1:0]     r_rd_ptr;
  logic [CntW-1:0]     r_count;

  logic [DATAWIDTH-1:0] r_m_data;
  logic                 r_m_valid;
  logic                 r_m_last;
  logic                 r_done;

  logic                w_busy;
  logic                w_issue_first;
  logic                w_issue_run;
  logic                w_issue;
  logic                w_issue_last;
  logic                w_drain_exit;
  logic                w_zero_done;
  logic                w_len_zero;
  logic                w_len_one;
  logic                w_rem_one;
  logic                w_credit;
  logic [1:0]          w_inflight;
  logic [CntW:0]       w_occupancy;
  logic [MEMWIDTH-1:0] w_issue_addr;
  logic [MEMWIDTH:0]   w_issue_rem;
  logic                w_push;
  logic                w_pop;
  logic [DATAWIDTH:0]  w_head;

  assign w_len_zero = (length == '0);
  assign w_len_one  = (length == LenOne);
  assign w_rem_one  = (r_remaining == LenOne);

  // Reads already issued but not yet in the FIFO still need a slot, so they count as used.
  assign w_inflight  = {1'b0, r_tag_v[0]} + {1'b0, r_tag_v[1]};
  assign w_occupancy = {1'b0, r_count} + (CntW + 1)'(w_inflight);
  assign w_credit    = (w_occupancy < DepthOcc);

  // FSM: state register
  always_ff @(posedge clk) begin : p_state
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin : p_next
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (start && !w_len_zero) begin
          w_state_next = w_len_one ? StDrain : StIssue;
        end
      end
      StIssue: begin
        if (w_issue_run && w_rem_one) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (w_drain_exit) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM: outputs and strobes
  always_comb begin : p_out
    w_busy        = 1'b0;
    w_issue_first = 1'b0;
    w_issue_run   = 1'b0;
    w_drain_exit  = 1'b0;
    w_zero_done   = 1'b0;
    unique case (r_state)
      StIdle: begin
        // The first read goes out on the accepting edge itself.
        w_issue_first = start && !w_len_zero;
        w_zero_done   = start && w_len_zero;
      end
      StIssue: begin
        w_busy      = 1'b1;
        w_issue_run = w_credit;
      end
      StDrain: begin
        w_busy       = 1'b1;
        w_drain_exit = r_m_valid && r_m_last && m_ready;
      end
      default: ;
    endcase
  end

  assign w_issue      = w_issue_first | w_issue_run;
  assign w_issue_addr = w_issue_first ? start_addr : r_next_addr;
  assign w_issue_rem  = w_issue_first ? length : r_remaining;
  assign w_issue_last = (w_issue_rem == LenOne);

  always_ff @(posedge clk) begin : p_issue
    if (!rst_n) begin
      r_raddr     <= '0;
      r_next_addr <= '0;
      r_remaining <= '0;
      r_tag_v     <= '0;
      r_tag_last  <= '0;
    end else begin
      if (w_issue) begin
        r_raddr     <= w_issue_addr;
        r_next_addr <= w_issue_addr + AddrOne;
        r_remaining <= w_issue_rem - LenOne;
      end
      // Stage 1 lines up with rdata: the RAM registers raddr one edge after we do.
      r_tag_v    <= {r_tag_v[0], w_issue};
      r_tag_last <= {r_tag_last[0], w_issue & w_issue_last};
    end
  end

  assign w_push = r_tag_v[1];
  assign w_pop  = (r_count != '0) && (!r_m_valid || m_ready);
  assign w_head = r_fifo[r_rd_ptr];

  always_ff @(posedge clk) begin : p_fifo_mem
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {r_tag_last[1], rdata};
    end
  end

  always_ff @(posedge clk) begin : p_fifo_ctrl
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);

      if (w_pop) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_head[DATAWIDTH-1:0];
        r_m_last  <= w_head[DATAWIDTH];
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
        r_m_last  <= 1'b0;
      end

      r_done <= w_zero_done | w_drain_exit;
    end
  end

  assign busy    = w_busy;
  assign done    = r_done;
  assign raddr   = r_raddr;
  assign m_data  = r_m_data;
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_count == DepthCnt)));

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed and randomized bench for bram_stream_reader against a RAM model and a queue-based
// reference of the expected word sequence.
module tb_bram_stream_reader;
  localparam int MW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [MW-1:0] start_addr;
  logic [MW:0]   length;
  logic          busy;
  logic          done;
  logic [MW-1:0] raddr;
  logic [DW-1:0] rdata;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;

  logic [DW-1:0] ram [DEPTH];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // RAM with a registered read, as in the real block RAM
  always @(posedge clk) rdata <= ram[raddr];

  bram_stream_reader #(
    .MEMWIDTH  (MW),
    .DATAWIDTH (DW),
    .FIFO_DEPTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .raddr     (raddr),
    .rdata     (rdata),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 ready always high, 1 ready pattern 1,0,0,1, 2 random ready.
  // intr_k: cycle at which a conflicting start is driven; abort_k: cycle at which reset hits.
  task automatic run_xfer(input logic [MW-1:0] addr, input int len, input int mode,
                          input int intr_k, input int abort_k);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] exp_word;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          prev_stall;
    logic          rdy;
    logic          finished;
    logic          exp_done;
    logic          exp_busy;
    int            beats;
    int            lasts;
    int            dones;
    int            last_hs_k;
    int            budget;

    for (int i = 0; i < len; i++) exp_q.push_back(ram[(int'(addr) + i) % DEPTH]);
    beats      = 0;
    lasts      = 0;
    dones      = 0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    finished   = 1'b0;
    last_hs_k  = (len == 0) ? 0 : -10;
    budget     = 16 * len + 40;

    @(negedge clk);
    start      = 1'b1;
    start_addr = addr;
    length     = (MW + 1)'(len);
    m_ready    = 1'b1;
    @(negedge clk);
    start      = 1'b0;

    for (int k = 1; k <= budget; k++) begin
      if (k <= 3) check("valid_early", m_valid, 1'b0);
      if (k == 4 && len > 0) check("first_valid", m_valid, 1'b1);
      if (prev_stall) begin
        check("hold_valid", m_valid, 1'b1);
        check("hold_data", m_data, prev_data);
        check("hold_last", m_last, prev_last);
      end
      exp_done = (last_hs_k >= 0) && (k == last_hs_k + 1);
      exp_busy = (len > 0) && !((last_hs_k >= 0) && (k > last_hs_k));
      check("done", done, exp_done);
      check("busy", busy, exp_busy);
      if (done) dones++;
      if (last_hs_k >= 0 && k == last_hs_k + 2) begin
        finished = 1'b1;
        break;
      end

      if (k == abort_k) begin
        m_ready = 1'b0;
        start   = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        check("abort_valid", m_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_last", m_last, 1'b0);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
          @(negedge clk);
          check("post_abort_done", done, 1'b0);
          check("post_abort_valid", m_valid, 1'b0);
        end
        return;
      end

      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
      else                rdy = 1'($urandom_range(0, 1));
      m_ready = rdy;

      if (k == intr_k) begin
        start      = 1'b1;
        start_addr = addr + 10'd13;
        length     = 11'd5;
      end else begin
        start = 1'b0;
      end

      if (m_valid && rdy) begin
        if (exp_q.size() == 0) begin
          check("beat_count_excess", beats + 1, len);
        end else begin
          exp_word = exp_q.pop_front();
          check("data", m_data, exp_word);
          check("last", m_last, exp_q.size() == 0);
          if (mode == 0) check("beat_timing", k, 4 + beats);
          if (exp_q.size() == 0) last_hs_k = k;
        end
        beats++;
        if (m_last) lasts++;
      end
      prev_stall = m_valid && !rdy;
      prev_data  = m_data;
      prev_last  = m_last;
      @(negedge clk);
    end
    start = 1'b0;

    check("finished", finished, 1'b1);
    check("beat_count", beats, len);
    check("last_count", lasts, (len > 0) ? 1 : 0);
    check("done_count", dones, 1);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    start_addr = '0;
    length     = '0;
    m_ready    = 1'b0;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);

    repeat (2) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_raddr", raddr, '0);
    check("rst_valid", m_valid, 1'b0);
    check("rst_last", m_last, 1'b0);
    check("rst_data", m_data, '0);
    rst_n = 1'b1;

    run_xfer(10'h010, 8, 0, -1, -1);
    run_xfer(10'h010, 8, 1, -1, -1);
    run_xfer(10'h3FE, 4, 0, -1, -1);
    run_xfer(10'h000, 0, 0, -1, -1);
    run_xfer(10'h100, 16, 1, 6, -1);
    run_xfer(10'h200, 16, 0, -1, 7);
    run_xfer(10'h020, 5, 0, -1, -1);
    run_xfer(10'h3FF, 1, 1, -1, -1);

    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom();
    run_xfer(10'h155, 1024, 2, -1, -1);
    for (int t = 0; t < 4; t++) begin
      run_xfer(10'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 2, -1, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
